minicpu_ser_opr: RTL and testbench

MINICPU_SER_OPR -- requirements
Module: minicpu_ser_opr

---
 rtl/minicpu_ser_opr_if.sv | 21 ++
 rtl/minicpu_ser_opr.sv | 115 +++++++++++
 tb/tb_minicpu_ser_opr.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/minicpu_ser_opr_if.sv
// Instruction-fetch handshake and serial-ALU control bundle of the mini CPU operand sequencer.
interface minicpu_ser_opr_if;
    logic       IR_Vld;
    logic [7:0] IR;
    logic       IR_Rdy;
    logic       CE;
    logic [4:0] I;
    logic       Op;
    logic       Done;
    logic       Halt;

    modport master (
        output IR_Vld, IR,
        input  IR_Rdy, CE, I, Op, Done, Halt
    );

    modport slave (
        input  IR_Vld, IR,
        output IR_Rdy, CE, I, Op, Done, Halt
    );
endinterface

// File: rtl/minicpu_ser_opr.sv
// Prefix-building operand register and serializer: turns instruction bytes into
// N-cycle LSB-first ALU windows with a registered function code.
module minicpu_ser_opr #(
    parameter int unsigned N = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    minicpu_ser_opr_if.slave   bus
);
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(N - 2);
    localparam logic [3:0] OPC_NFX = 4'h6;
    localparam logic [3:0] OPC_PFX = 4'h7;
    localparam logic [3:0] OPC_EXE = 4'hF;
    localparam logic [4:0] FN_HLT  = 5'b11111;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_HALT} state_t;

    state_t          state;
    logic [N-1:0]    opr;
    logic [N-1:0]    sh;
    logic [CW-1:0]   cnt;
    logic [4:0]      func;
    logic            ce;
    logic            op;
    logic            done;
    logic            halt;
    logic            rdy;

    logic [N-1:0]    opf_c;
    logic [4:0]      fn_c;
    logic            accept_c;

    // Effective operand and the function code a non-prefix byte would issue
    always_comb begin
        opf_c    = opr | N'(bus.IR[3:0]);
        fn_c     = (bus.IR[7:4] == OPC_EXE) ? {1'b1, opf_c[3:0]} : {1'b0, bus.IR[7:4]};
        accept_c = bus.IR_Vld & rdy;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= S_IDLE;
            opr   <= '0;
            sh    <= '0;
            cnt   <= '0;
            func  <= '0;
            ce    <= 1'b0;
            op    <= 1'b0;
            done  <= 1'b0;
            halt  <= 1'b0;
            rdy   <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept_c) begin
                        if (bus.IR[7:4] == OPC_PFX) begin
                            opr <= opf_c << 4;
                        end else if (bus.IR[7:4] == OPC_NFX) begin
                            opr <= (~opf_c) << 4;
                        end else begin
                            func <= fn_c;
                            opr  <= '0;
                            cnt  <= '0;
                            rdy  <= 1'b0;
                            if (fn_c == FN_HLT) begin
                                state <= S_HALT;
                                halt  <= 1'b1;
                            end else begin
                                // Bit 0 goes out on the first CE cycle; sh keeps the rest
                                state <= S_SHIFT;
                                ce    <= 1'b1;
                                op    <= opf_c[0];
                                sh    <= opf_c >> 1;
                                done  <= (CNT_LAST == '0);
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                        rdy   <= 1'b1;
                        ce    <= 1'b0;
                        op    <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        op   <= sh[0];
                        sh   <= sh >> 1;
                        done <= (cnt == CNT_PRE);
                    end
                end
                S_HALT: begin
                    rdy  <= 1'b0;
                    ce   <= 1'b0;
                    halt <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    rdy   <= 1'b1;
                    ce    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.IR_Rdy = rdy;
    assign bus.CE     = ce;
    assign bus.I      = func;
    assign bus.Op     = op;
    assign bus.Done   = done;
    assign bus.Halt   = halt;
endmodule

// File: tb/tb_minicpu_ser_opr.sv
// Directed bench for minicpu_ser_opr: driver pushes expected windows, monitor checks them.
module tb_minicpu_ser_opr;
    logic Clk;
    logic Rst;

    minicpu_ser_opr_if bus ();

    minicpu_ser_opr #(.N(16)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [4:0]  i;
        logic [15:0] d;
        logic [5:0]  len;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   win_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic push(input logic [4:0] i, input logic [15:0] d, input logic [5:0] len);
        exp_t e;
        e.i = i;
        e.d = d;
        e.len = len;
        sb.push_back(e);
    endtask

    // Issue one byte; gap = expected cycles from acceptance until IR_Rdy returns (0 = skip)
    task automatic send(input logic [7:0] b, input int gap);
        int k = 0;
        int n = 1;
        while (!bus.IR_Rdy && k < 100) begin
            step();
            k++;
        end
        chk("send_rdy", 32'(bus.IR_Rdy), 32'd1);
        bus.IR_Vld = 1'b1;
        bus.IR     = b;
        step();
        bus.IR_Vld = 1'b0;
        if (gap != 0) begin
            while (!bus.IR_Rdy && n < 100) begin
                step();
                n++;
            end
            chk("issue_gap", 32'(n), 32'(gap));
        end
    endtask

    // Monitor: collect each CE window and compare against the scoreboard head
    initial begin
        int          wl = 0;
        logic [4:0]  wi = '0;
        logic [15:0] wd = '0;
        bit          i_stable = 1'b1;
        bit          done_bad = 1'b0;
        bit          done_seen = 1'b0;
        forever begin
            @(negedge Clk);
            if (bus.CE === 1'b1) begin
                if (wl == 0) begin
                    wi = bus.I;
                    wd = '0;
                    i_stable = 1'b1;
                    done_bad = 1'b0;
                    done_seen = 1'b0;
                end else if (bus.I !== wi) begin
                    i_stable = 1'b0;
                end
                if (wl < 16) wd[wl] = bus.Op;
                if (bus.Done === 1'b1) begin
                    done_seen = 1'b1;
                    if (wl != 15) done_bad = 1'b1;
                end
                wl++;
            end else begin
                if (!Rst && (bus.Op !== 1'b0 || bus.Done !== 1'b0)) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_outputs: Op=%b Done=%b outside a window", bus.Op, bus.Done);
                end
                if (wl > 0) begin
                    win_count++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: len=%0d I=%b data=%h", wl, wi, wd);
                    end else begin
                        exp_t e;
                        logic [15:0] mask;
                        e = sb.pop_front();
                        mask = (e.len >= 6'd16) ? 16'hFFFF : 16'((17'd1 << e.len) - 17'd1);
                        checks++;
                        if (wl != int'(e.len) || done_bad || (done_seen != (e.len == 6'd16))) begin
                            errors++;
                            $display("FAIL win_len_done: len=%0d done_seen=%0d done_misplaced=%0d expected len=%0d",
                                     wl, done_seen, done_bad, e.len);
                        end
                        checks++;
                        if (wi !== e.i || !i_stable || ((wd & mask) !== (e.d & mask))) begin
                            errors++;
                            $display("FAIL win_data: I=%b data=%h stable=%0d expected I=%b data=%h",
                                     wi, wd & mask, i_stable, e.i, e.d & mask);
                        end
                    end
                    wl = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] seq [3];
        int idx;
        int guard;
        Rst = 1'b1;
        bus.IR_Vld = 1'b0;
        bus.IR = 8'h00;
        repeat (3) step();
        Rst = 1'b0;
        step();
        chk("rst_ce",   32'(bus.CE),     32'd0);
        chk("rst_op",   32'(bus.Op),     32'd0);
        chk("rst_done", 32'(bus.Done),   32'd0);
        chk("rst_halt", 32'(bus.Halt),   32'd0);
        chk("rst_rdy",  32'(bus.IR_Rdy), 32'd1);
        chk("rst_i",    32'(bus.I),      32'd0);

        push(5'b00001, 16'h0005, 6'd16);
        send(8'h15, 17);

        send(8'h7A, 1);
        chk("pfx_no_ce", 32'(bus.CE), 32'd0);
        push(5'b00001, 16'h00A3, 6'd16);
        send(8'h13, 17);
        push(5'b00001, 16'h0001, 6'd16);
        send(8'h11, 17);

        send(8'h60, 1);
        chk("nfx_no_ce", 32'(bus.CE), 32'd0);
        push(5'b00001, 16'hFFFF, 6'd16);
        send(8'h1F, 17);

        push(5'b11010, 16'h000A, 6'd16);
        send(8'hFA, 17);
        send(8'h75, 1);
        push(5'b10010, 16'h0052, 6'd16);
        send(8'hF2, 17);

        push(5'b00010, 16'h000C, 6'd16);
        send(8'h2C, 17);
        push(5'b10000, 16'h0000, 6'd16);
        send(8'hF0, 17);

        // Abort a window on its 8th CE cycle
        push(5'b00001, 16'h0003, 6'd8);
        send(8'h13, 0);
        repeat (7) step();
        Rst = 1'b1;
        step();
        chk("abort_ce",   32'(bus.CE),     32'd0);
        chk("abort_done", 32'(bus.Done),   32'd0);
        chk("abort_rdy",  32'(bus.IR_Rdy), 32'd1);
        Rst = 1'b0;
        push(5'b00001, 16'h0001, 6'd16);
        send(8'h11, 17);

        // IR_Vld held high with junk bytes while busy
        seq[0] = 8'h23;
        seq[1] = 8'h34;
        seq[2] = 8'h45;
        push(5'b00010, 16'h0003, 6'd16);
        push(5'b00011, 16'h0004, 6'd16);
        push(5'b00100, 16'h0005, 6'd16);
        idx = 0;
        guard = 0;
        bus.IR_Vld = 1'b1;
        bus.IR = seq[0];
        while (guard < 200) begin
            step();
            guard++;
            if (bus.IR_Rdy) begin
                idx++;
                if (idx == 3) break;
                bus.IR = seq[idx];
            end else begin
                bus.IR = {4'h8, 4'(guard)};
            end
        end
        bus.IR_Vld = 1'b0;
        chk("stream_accepts", 32'(idx), 32'd3);
        chk("window_count", 32'(win_count), 32'd13);

        // Halt is absorbing until reset
        send(8'hFF, 0);
        chk("halt_set", 32'(bus.Halt),   32'd1);
        chk("halt_rdy", 32'(bus.IR_Rdy), 32'd0);
        chk("halt_i",   32'(bus.I),      32'h1F);
        bus.IR_Vld = 1'b1;
        bus.IR = 8'h15;
        repeat (20) step();
        bus.IR_Vld = 1'b0;
        chk("halt_hold", 32'(bus.Halt),   32'd1);
        chk("halt_ce",   32'(bus.CE),     32'd0);
        chk("halt_rdy2", 32'(bus.IR_Rdy), 32'd0);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        step();
        chk("halt_clr", 32'(bus.Halt),   32'd0);
        chk("halt_rdy3", 32'(bus.IR_Rdy), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        chk("window_total", 32'(win_count), 32'd13);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
